axi4_lite_mem_slave: RTL

//  Parametrised AXI4-Lite slave with an integrated word-addressed memory.

---
 rtl/axi4_lite_mem_slave_if.sv | 49 ++++
 rtl/axi4_lite_mem_slave.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/axi4_lite_mem_slave_if.sv
//------------------------------------------------------------------------------
// Module  : axi4_lite_mem_slave_if
// Brief   : AXI4-Lite bus bundle with master/slave views.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface axi4_lite_mem_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  AWVALID;
  logic [ADDR_W-1:0]     AWADDR;
  logic [2:0]            AWPROT;
  logic                  AWREADY;
  logic                  WVALID;
  logic [DATA_W-1:0]     WDATA;
  logic [DATA_W/8-1:0]   WSTRB;
  logic                  WREADY;
  logic                  BVALID;
  logic [1:0]            BRESP;
  logic                  BREADY;
  logic                  ARVALID;
  logic [ADDR_W-1:0]     ARADDR;
  logic [2:0]            ARPROT;
  logic                  ARREADY;
  logic                  RVALID;
  logic [DATA_W-1:0]     RDATA;
  logic [1:0]            RRESP;
  logic                  RREADY;

  modport slave (
    input  AWVALID, AWADDR, AWPROT, output AWREADY,
    input  WVALID, WDATA, WSTRB,    output WREADY,
    output BVALID, BRESP,           input  BREADY,
    input  ARVALID, ARADDR, ARPROT, output ARREADY,
    output RVALID, RDATA, RRESP,    input  RREADY
  );

  modport master (
    output AWVALID, AWADDR, AWPROT, input  AWREADY,
    output WVALID, WDATA, WSTRB,    input  WREADY,
    input  BVALID, BRESP,           output BREADY,
    output ARVALID, ARADDR, ARPROT, input  ARREADY,
    input  RVALID, RDATA, RRESP,    output RREADY
  );
endinterface

`default_nettype wire

// File: rtl/axi4_lite_mem_slave.sv
//------------------------------------------------------------------------------
// Module  : axi4_lite_mem_slave
// Brief   : AXI4-Lite slave with integrated word-addressed, byte-strobed memory.
//           Define AXIL_MEM_RANGE_CHK_EN to reject out-of-window accesses (SLVERR).
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module axi4_lite_mem_slave #(
  parameter int              DATA_W    = 32,
  parameter int              ADDR_W    = 32,
  parameter int              DEPTH     = 256,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic                 iCLK,
  input  logic                 iRST,
  axi4_lite_mem_slave_if.slave s
);
  localparam int c_BYTES = DATA_W / 8;
  localparam int c_LSB   = $clog2(c_BYTES);
  localparam int c_IDX_W = $clog2(DEPTH);

  logic [DATA_W-1:0]  r_mem [DEPTH];

  logic               r_live;
  logic               r_aw_full;
  logic               r_aw_err;
  logic [c_IDX_W-1:0] r_aw_idx;
  logic               r_w_full;
  logic [DATA_W-1:0]  r_w_data;
  logic [c_BYTES-1:0] r_w_strb;
  logic               r_bvalid;
  logic [1:0]         r_bresp;
  logic               r_rvalid;
  logic [1:0]         r_rresp;
  logic [DATA_W-1:0]  r_rdata;

  logic [ADDR_W-1:0]  w_aw_off;
  logic [ADDR_W-1:0]  w_ar_off;
  logic [c_IDX_W-1:0] w_aw_idx;
  logic [c_IDX_W-1:0] w_ar_idx;
  logic               w_aw_err;
  logic               w_ar_err;
  logic               w_aw_hs;
  logic               w_w_hs;
  logic               w_ar_hs;
  logic               w_b_hs;
  logic               w_r_hs;
  logic               w_commit;
  logic               w_unused;

  // Offset from the window base; subtraction wraps so below-base addresses look huge.
  assign w_aw_off = s.AWADDR - BASE_ADDR;
  assign w_ar_off = s.ARADDR - BASE_ADDR;
  assign w_aw_idx = w_aw_off[c_LSB +: c_IDX_W];
  assign w_ar_idx = w_ar_off[c_LSB +: c_IDX_W];

`ifdef AXIL_MEM_RANGE_CHK_EN
  localparam logic [ADDR_W:0] c_SPAN = (ADDR_W+1)'(DEPTH * c_BYTES);
  assign w_aw_err = ({1'b0, w_aw_off} >= c_SPAN);
  assign w_ar_err = ({1'b0, w_ar_off} >= c_SPAN);
`else
  assign w_aw_err = 1'b0;
  assign w_ar_err = 1'b0;
`endif

  assign w_unused = ^{s.AWPROT, s.ARPROT, w_aw_off, w_ar_off};

  // r_live keeps every ready low during reset and the first cycle after it.
  assign s.AWREADY = r_live & ~r_aw_full;
  assign s.WREADY  = r_live & ~r_w_full;
  assign s.ARREADY = r_live & ~r_rvalid;
  assign s.BVALID  = r_bvalid;
  assign s.BRESP   = r_bresp;
  assign s.RVALID  = r_rvalid;
  assign s.RRESP   = r_rresp;
  assign s.RDATA   = r_rdata;

  assign w_aw_hs  = s.AWVALID & r_live & ~r_aw_full;
  assign w_w_hs   = s.WVALID  & r_live & ~r_w_full;
  assign w_ar_hs  = s.ARVALID & r_live & ~r_rvalid;
  assign w_b_hs   = r_bvalid & s.BREADY;
  assign w_r_hs   = r_rvalid & s.RREADY;
  assign w_commit = r_aw_full & r_w_full & ~r_bvalid;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      r_live    <= 1'b0;
      r_aw_full <= 1'b0;
      r_aw_err  <= 1'b0;
      r_aw_idx  <= '0;
      r_w_full  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      r_rvalid  <= 1'b0;
      r_rresp   <= 2'b00;
      r_rdata   <= '0;
    end else begin
      r_live <= 1'b1;

      if (w_aw_hs) begin
        r_aw_full <= 1'b1;
        r_aw_idx  <= w_aw_idx;
        r_aw_err  <= w_aw_err;
      end else if (w_commit) begin
        r_aw_full <= 1'b0;
      end

      if (w_w_hs) begin
        r_w_full <= 1'b1;
        r_w_data <= s.WDATA;
        r_w_strb <= s.WSTRB;
      end else if (w_commit) begin
        r_w_full <= 1'b0;
      end

      if (w_commit) begin
        r_bvalid <= 1'b1;
        r_bresp  <= r_aw_err ? 2'b10 : 2'b00;
      end else if (w_b_hs) begin
        r_bvalid <= 1'b0;
        r_bresp  <= 2'b00;
      end

      // Memory array is read here before the same-edge commit lands: read-before-write.
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rresp  <= w_ar_err ? 2'b10 : 2'b00;
        r_rdata  <= w_ar_err ? '0 : r_mem[w_ar_idx];
      end else if (w_r_hs) begin
        r_rvalid <= 1'b0;
        r_rresp  <= 2'b00;
        r_rdata  <= '0;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (!iRST && w_commit && !r_aw_err) begin
      for (int i = 0; i < c_BYTES; i++) begin
        if (r_w_strb[i]) begin
          r_mem[r_aw_idx][8*i +: 8] <= r_w_data[8*i +: 8];
        end
      end
    end
  end

endmodule

`default_nettype wire
